// File: rtl/lsu_align_ext.sv
// lsu_align_ext: load/store lane steering, byte enables, load extension and split of word-crossing accesses
module lsu_align_ext #(
  parameter int XLEN             = 64,
  parameter int ADDR_W           = 64,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                reqValid_i,
  output logic                reqReady_o,
  input  logic                reqWrite_i,
  input  logic [1:0]          reqSize_i,
  input  logic                reqSigned_i,
  input  logic [ADDR_W-1:0]   reqAddr_i,
  input  logic [XLEN-1:0]     reqWData_i,
  output logic                memValid_o,
  input  logic                memReady_i,
  output logic                memWrite_o,
  output logic [ADDR_W-1:0]   memAddr_o,
  output logic [XLEN-1:0]     memWData_o,
  output logic [XLEN/8-1:0]   memBe_o,
  input  logic                memRValid_i,
  input  logic [XLEN-1:0]     memRData_i,
  output logic                rspValid_o,
  output logic [XLEN-1:0]     rspData_o,
  output logic                rspErr_o
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int BW = 2 * NB;
  localparam logic [2:0] IDLE = 3'd0, ISSUE0 = 3'd1, WAIT0 = 3'd2, ISSUE1 = 3'd3, WAIT1 = 3'd4, RESP = 3'd5;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, base, mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d, lo_q, lo_d, hi_q, hi_d, raw, mask, ext;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d, rsp_data_q, rsp_data_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d, wr_q, wr_d;
  logic              ready_q, mem_valid_q, mem_write_q, rsp_valid_q, rsp_err_q, rsp_err_d;
  logic [NB-1:0]     mem_be_q, mem_be_d;
  logic              accept, misal, split, err, sign_bit, iss0, iss1;
  logic [OW-1:0]     off;
  logic [4:0]        sz;
  logic [7:0]        bits;
  logic [BW-1:0]     be_w;
  logic [2*XLEN-1:0] wd_w;
  always_comb begin
    accept  = reqValid_i && state_q == IDLE;
    addr_d  = accept ? reqAddr_i : addr_q;
    wdata_d = accept ? reqWData_i : wdata_q;
    size_d  = accept ? reqSize_i : size_q;
    sgn_d   = accept ? reqSigned_i : sgn_q;
    wr_d    = accept ? reqWrite_i : wr_q;
    off     = addr_d[OW-1:0];
    sz      = 5'd1 << size_d;
    misal   = (5'(off) & (sz - 5'd1)) != 5'd0;
    split   = 5'(off) + sz > 5'(NB);
    err     = (XLEN == 32 && size_d == 2'd3) || (misal && ALLOW_MISALIGNED == 0);
    base    = {addr_d[ADDR_W-1:OW], {OW{1'b0}}};
    be_w    = ((BW'(1) << sz) - BW'(1)) << off;
    wd_w    = {{XLEN{1'b0}}, wdata_d} << {off, 3'b000};
    lo_d    = (state_q == WAIT0 && memRValid_i) ? memRData_i : accept ? '0 : lo_q;
    hi_d    = (state_q == WAIT1 && memRValid_i) ? memRData_i : accept ? '0 : hi_q;
    raw     = XLEN'({hi_d, lo_d} >> {off, 3'b000});
    bits    = 8'd8 << size_d;
    // a shift by the full width yields 0, so the mask saturates to all ones for full-word loads
    mask     = (XLEN'(1) << bits) - XLEN'(1);
    sign_bit = |(raw & (mask ^ (mask >> 1)));
    ext      = (raw & mask) | ((sgn_d && sign_bit) ? ~mask : '0);
    state_d = state_q == IDLE   ? (accept ? (err ? RESP : ISSUE0) : IDLE)
            : state_q == ISSUE0 ? (!memReady_i ? ISSUE0 : wr_q ? (split ? ISSUE1 : RESP) : WAIT0)
            : state_q == WAIT0  ? (!memRValid_i ? WAIT0 : split ? ISSUE1 : RESP)
            : state_q == ISSUE1 ? (!memReady_i ? ISSUE1 : wr_q ? RESP : WAIT1)
            : state_q == WAIT1  ? (memRValid_i ? RESP : WAIT1)
            : IDLE;
    iss0        = state_d == ISSUE0;
    iss1        = state_d == ISSUE1;
    mem_addr_d  = iss0 ? base : iss1 ? base + ADDR_W'(NB) : '0;
    mem_be_d    = iss0 ? be_w[NB-1:0] : iss1 ? be_w[BW-1:NB] : '0;
    mem_wdata_d = !wr_d ? '0 : iss0 ? wd_w[XLEN-1:0] : iss1 ? wd_w[2*XLEN-1:XLEN] : '0;
    rsp_err_d   = accept && err;
    rsp_data_d  = (state_d == RESP && state_q != IDLE && !wr_q) ? ext : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      wr_q        <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      ready_q     <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      wr_q        <= wr_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      ready_q     <= state_d == IDLE;
      mem_valid_q <= iss0 || iss1;
      mem_write_q <= (iss0 || iss1) && wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      rsp_valid_q <= state_d == RESP;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
  assign reqReady_o = ready_q;
  assign memValid_o = mem_valid_q;
  assign memWrite_o = mem_write_q;
  assign memAddr_o  = mem_addr_q;
  assign memWData_o = mem_wdata_q;
  assign memBe_o    = mem_be_q;
  assign rspValid_o = rsp_valid_q;
  assign rspData_o  = rsp_data_q;
  assign rspErr_o   = rsp_err_q;
endmodule

// File: tb/tb_lsu_align_ext.sv
// tb_lsu_align_ext: directed vectors with hand-computed expectations for lsu_align_ext
module tb_lsu_align_ext;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        rv0 = 1'b0, rv1 = 1'b0, rv2 = 1'b0;
  logic        req_write = 1'b0, req_signed = 1'b0, mem_ready = 1'b1, mem_rvalid = 1'b0;
  logic [1:0]  req_size = '0;
  logic [63:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic        ready0, mvalid0, mwrite0, rvalid0, rerr0;
  logic [63:0] maddr0, mwdata0, rdata0;
  logic [7:0]  mbe0;
  logic        ready1, mvalid1, mwrite1, rvalid1, rerr1;
  logic [63:0] maddr1, mwdata1, rdata1;
  logic [7:0]  mbe1;
  logic        ready2, mvalid2, mwrite2, rvalid2, rerr2;
  logic [63:0] maddr2;
  logic [31:0] mwdata2, rdata2;
  logic [3:0]  mbe2;
  int          total = 0, bad = 0, nb = 0, seen = 0;
  logic [63:0] b_addr[4], b_wd[4];
  logic [7:0]  b_be[4];
  logic        b_wr[4];

  always #5 clk = ~clk;

  lsu_align_ext dut0 (
    .clk(clk), .rst_n(rst_n), .reqValid_i(rv0), .reqReady_o(ready0), .reqWrite_i(req_write),
    .reqSize_i(req_size), .reqSigned_i(req_signed), .reqAddr_i(req_addr), .reqWData_i(req_wdata),
    .memValid_o(mvalid0), .memReady_i(mem_ready), .memWrite_o(mwrite0), .memAddr_o(maddr0),
    .memWData_o(mwdata0), .memBe_o(mbe0), .memRValid_i(mem_rvalid), .memRData_i(mem_rdata),
    .rspValid_o(rvalid0), .rspData_o(rdata0), .rspErr_o(rerr0));

  lsu_align_ext #(.ALLOW_MISALIGNED(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .reqValid_i(rv1), .reqReady_o(ready1), .reqWrite_i(req_write),
    .reqSize_i(req_size), .reqSigned_i(req_signed), .reqAddr_i(req_addr), .reqWData_i(req_wdata),
    .memValid_o(mvalid1), .memReady_i(mem_ready), .memWrite_o(mwrite1), .memAddr_o(maddr1),
    .memWData_o(mwdata1), .memBe_o(mbe1), .memRValid_i(1'b0), .memRData_i(mem_rdata),
    .rspValid_o(rvalid1), .rspData_o(rdata1), .rspErr_o(rerr1));

  lsu_align_ext #(.XLEN(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .reqValid_i(rv2), .reqReady_o(ready2), .reqWrite_i(req_write),
    .reqSize_i(req_size), .reqSigned_i(req_signed), .reqAddr_i(req_addr), .reqWData_i(req_wdata[31:0]),
    .memValid_o(mvalid2), .memReady_i(mem_ready), .memWrite_o(mwrite2), .memAddr_o(maddr2),
    .memWData_o(mwdata2), .memBe_o(mbe2), .memRValid_i(1'b0), .memRData_i(mem_rdata[31:0]),
    .rspValid_o(rvalid2), .rspData_o(rdata2), .rspErr_o(rerr2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic w, input logic [1:0] sz, input logic sg, input logic [63:0] a, input logic [63:0] wd);
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  // one request on dut0 with a memory that accepts at once and returns read data one cycle later
  task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [63:0] a, input logic [63:0] wd, input logic [63:0] lo, input logic [63:0] hi,
                     input int exp_lat, input logic [63:0] exp_data);
    int lat, rc;
    logic acc, rd;
    nb  = 0;
    rc  = 0;
    lat = 0;
    set_req(w, sz, sg, a, wd);
    rv0 = 1'b1;
    do begin
      acc = mvalid0 && mem_ready;
      rd  = acc && !mwrite0;
      if (acc && nb < 4) begin
        b_addr[nb] = maddr0;
        b_be[nb]   = mbe0;
        b_wd[nb]   = mwdata0;
        b_wr[nb]   = mwrite0;
        nb++;
      end
      tick();
      lat++;
      rv0        = 1'b0;
      mem_rvalid = rd;
      mem_rdata  = !rd ? 64'h0 : (rc == 0) ? lo : hi;
      if (rd) rc++;
    end while (!rvalid0 && lat < 20);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_data"}, rdata0, exp_data);
    check({tag, "_err"}, {63'd0, rerr0}, 64'd0);
    tick();
    mem_rvalid = 1'b0;
    check({tag, "_pulse"}, {62'd0, rvalid0, ready0}, 64'd1);
  endtask

  initial begin
    tick();
    check("rst_ready", {63'd0, ready0}, 64'd1);
    check("rst_mem", {mvalid0, mwrite0, mbe0, maddr0[31:0]}, 64'd0);
    check("rst_wd", mwdata0, 64'd0);
    check("rst_rsp", {rvalid0, rerr0, rdata0[31:0]}, 64'd0);
    rst_n = 1'b1;
    tick();

    txn("lw_s", 1'b0, 2'd2, 1'b1, 64'h104, 64'h0, 64'h8000_0001_0000_0000, 64'h0, 3, 64'hFFFF_FFFF_8000_0001);
    check("lw_s_nb", 64'(nb), 64'd1);
    check("lw_s_addr", b_addr[0], 64'h100);
    check("lw_s_be", {56'd0, b_be[0]}, 64'hF0);

    txn("lbu", 1'b0, 2'd0, 1'b0, 64'h107, 64'h0, 64'h9C00_0000_0000_0000, 64'h0, 3, 64'h9C);
    check("lbu_be", {56'd0, b_be[0]}, 64'h80);
    txn("lbs", 1'b0, 2'd0, 1'b1, 64'h107, 64'h0, 64'h9C00_0000_0000_0000, 64'h0, 3, 64'hFFFF_FFFF_FFFF_FF9C);

    txn("sh_split", 1'b1, 2'd1, 1'b0, 64'h10F, 64'hBEEF, 64'h0, 64'h0, 3, 64'h0);
    check("sh_nb", 64'(nb), 64'd2);
    check("sh_b0_addr", b_addr[0], 64'h108);
    check("sh_b0_be", {56'd0, b_be[0]}, 64'h80);
    check("sh_b0_wd", b_wd[0], 64'hEF00_0000_0000_0000);
    check("sh_b1_addr", b_addr[1], 64'h110);
    check("sh_b1_be", {56'd0, b_be[1]}, 64'h01);
    check("sh_b1_wd", b_wd[1], 64'hBE);
    check("sh_wr", {62'd0, b_wr[0], b_wr[1]}, 64'd3);

    txn("ld_split", 1'b0, 2'd3, 1'b0, 64'h10C, 64'h0, 64'h4433_2211_0000_0000, 64'h0000_0000_8877_6655, 5, 64'h8877_6655_4433_2211);
    check("ld_nb", 64'(nb), 64'd2);
    check("ld_b0", {b_addr[0][55:0], b_be[0]}, {56'h108, 8'hF0});
    check("ld_b1", {b_addr[1][55:0], b_be[1]}, {56'h110, 8'h0F});

    txn("sw", 1'b1, 2'd2, 1'b0, 64'h100, 64'h1234_5678, 64'h0, 64'h0, 2, 64'h0);
    check("sw_beat", {b_addr[0][23:0], b_be[0], b_wd[0][31:0]}, {24'h100, 8'h0F, 32'h1234_5678});

    txn("lh_mis", 1'b0, 2'd1, 1'b1, 64'h101, 64'h0, 64'h0000_0000_0081_2300, 64'h0, 3, 64'hFFFF_FFFF_FFFF_8123);
    check("lh_mis_be", {56'd0, b_be[0]}, 64'h06);

    set_req(1'b0, 2'd2, 1'b0, 64'h102, 64'h0);
    rv1 = 1'b1;
    tick();
    rv1 = 1'b0;
    check("nomis_rsp", {62'd0, rvalid1, rerr1}, 64'd3);
    check("nomis_data", rdata1, 64'd0);
    check("nomis_mem", {63'd0, mvalid1}, 64'd0);
    tick();

    set_req(1'b0, 2'd3, 1'b0, 64'h100, 64'h0);
    rv2 = 1'b1;
    tick();
    rv2 = 1'b0;
    check("x32_d_err", {61'd0, rvalid2, rerr2, mvalid2}, 64'd6);
    tick();
    set_req(1'b1, 2'd2, 1'b0, 64'h100, 64'hCAFE_F00D);
    rv2 = 1'b1;
    tick();
    rv2 = 1'b0;
    check("x32_sw_beat", {maddr2[23:0], 3'd0, mvalid2, mbe2, mwdata2}, {24'h100, 3'd0, 1'b1, 4'hF, 32'hCAFE_F00D});
    tick();
    check("x32_sw_rsp", {62'd0, rvalid2, rerr2}, 64'd2);
    tick();

    mem_ready = 1'b0;
    set_req(1'b1, 2'd3, 1'b0, 64'h100, 64'h1122_3344_5566_7788);
    rv0 = 1'b1;
    tick();
    rv0 = 1'b0;
    repeat (4) begin
      check("stall_addr", {maddr0[55:0], 6'd0, mvalid0, mwrite0}, {56'h100, 8'h03});
      check("stall_be", {56'd0, mbe0}, 64'hFF);
      check("stall_wd", mwdata0, 64'h1122_3344_5566_7788);
      tick();
    end
    mem_ready = 1'b1;
    tick();
    check("stall_rsp", {63'd0, rvalid0}, 64'd1);
    tick();

    set_req(1'b0, 2'd2, 1'b0, 64'h100, 64'h0);
    rv0 = 1'b1;
    tick();
    rv0 = 1'b0;
    tick();
    check("rst_wait0", {62'd0, mvalid0, ready0}, 64'd0);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    check("rst_mid", {62'd0, ready0, mvalid0}, 64'd2);
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    seen = 0;
    repeat (5) begin
      if (rvalid0 || mvalid0) seen++;
      tick();
    end
    check("rst_late_rv", 64'(seen), 64'd0);
    check("rst_idle", {63'd0, ready0}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_align_ext.md
Name: lsu_align_ext

Overview:
Parametrised load/store alignment and extension unit that sits between the core's load/store path and a word-wide data memory. It generalises our load extension logic to every access size and to XLEN=32/64. It adds registered byte-lane steering, byte enables, signed/unsigned extension for all load sizes, and optional splitting of line-crossing misaligned accesses into two memory beats. A valid/ready handshake and an FSM connect it to a memory with one read outstanding.

Parameters:
XLEN, 64, data width in bits; legal values 32 or 64; memory word = XLEN/8 bytes (NB)
ADDR_W, 64, address width in bits
ALLOW_MISALIGNED, 1, 1 = misaligned accesses are performed (split if crossing a word); 0 = any misaligned access returns rspErr with no memory traffic

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
reqValid  input  1  core request valid
reqReady  output  1  unit can accept a request (high only in IDLE)
reqWrite  input  1  1 = store, 0 = load
reqSize  input  2  0 byte, 1 half, 2 word, 3 double (3 is illegal when XLEN=32)
reqSigned  input  1  loads: 1 = sign-extend, 0 = zero-extend
reqAddr  input  ADDR_W  byte address
reqWData  input  XLEN  store data, right-justified
memValid  output  1  memory request valid
memReady  input  1  memory accepts the request
memWrite  output  1  memory request is a write
memAddr  output  ADDR_W  word-aligned address (low log2(NB) bits zero)
memWData  output  XLEN  lane-steered store data
memBe  output  NB  byte enables
memRValid  input  1  read data valid
memRData  input  XLEN  read data word
rspValid  output  1  one-cycle completion pulse (loads and stores)
rspData  output  XLEN  extended load result; 0 for stores and errors
rspErr  output  1  qualifies rspValid: illegal size or disallowed misalignment

Behaviour:
- Reset (async, rst_n=0): state=IDLE; reqReady=1; memValid=0, memWrite=0, memAddr=0, memWData=0, memBe=0; rspValid=0, rspData=0, rspErr=0. All outputs are registered.
- Latched on accept (reqValid&&reqReady): off = addr[log2(NB)-1:0], sz = 1<<reqSize bytes, misaligned = off % sz != 0, split = off+sz > NB.
- FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
- IDLE: on accept, go to RESP with rspErr=1 if reqSize illegal or (misaligned and ALLOW_MISALIGNED=0). Otherwise go to ISSUE0.
- ISSUE0: memValid=1, memAddr = addr & ~(NB-1), memBe = ((1<<sz)-1)<<off truncated to NB bits, memWData = wdata<<(8*off) truncated. Outputs are held stable until memReady. On memReady: a write goes to ISSUE1 if split, else RESP; a read goes to WAIT0.
- WAIT0: memValid=0. On memRValid, capture lo=memRData, then go to ISSUE1 if split, else RESP.
- ISSUE1: memAddr = aligned addr + NB (wraps modulo 2^ADDR_W); memBe = ((1<<sz)-1) >> (NB-off); memWData = wdata >> (8*(NB-off)). On memReady: a write goes to RESP; a read goes to WAIT1.
- WAIT1: on memRValid, capture hi=memRData, then go to RESP.
- RESP: rspValid=1 for exactly one cycle, then IDLE.
  - Load result: raw = ({hi,lo} >> 8*off)[8*sz-1:0], with hi=0 for unsplit loads.
  - Extension: if sz==NB, rspData = raw; otherwise rspData = reqSigned ? sign-extend(raw) : zero-extend(raw).
- memRValid is ignored outside WAIT0/WAIT1, including stale data arriving after reset.
- Latency (memReady=1 immediately, memRValid one cycle after accept): unsplit load has rspValid 3 cycles after request accept; split load 5; unsplit store 2; split store 3; error 1.
- Reset asserted mid-operation aborts immediately with no response. An already issued memory beat is not retracted.
- No new request is accepted until the cycle after RESP, so throughput is one request per response.

Test Plan:
- XLEN=64, load word signed at addr 0x104, memRData=0x0000_0000_8000_0001_0000_0000 placed so the word is 0x80000001 -> memAddr=0x100, memBe=0xF0, rspData=0xFFFF_FFFF_8000_0001, rspValid 3 cycles after accept.
- Load byte unsigned at 0x107, memRData byte 7 = 0x9C -> rspData=0x9C; repeat with reqSigned=1 -> 0xFFFF_FFFF_FFFF_FF9C.
- Store half 0xBEEF at 0x10F (split) -> beat0: memAddr=0x108, memBe=0x80, memWData[63:56]=0xEF; beat1: memAddr=0x110, memBe=0x01, memWData[7:0]=0xBE; rspValid after beat1 acceptance.
- Load double at 0x10C (split), lo word=0x4433_2211_0000_0000, hi word=0x0000_0000_8877_6655 -> rspData=0x8877_6655_4433_2211.
- ALLOW_MISALIGNED=0, load word at 0x102 -> no memValid, rspValid+rspErr next cycle, rspData=0. XLEN=32 with reqSize=3 -> rspErr.
- memReady held low 4 cycles in ISSUE0 -> memAddr/memBe/memWData stable throughout. rst_n pulsed in WAIT0 -> IDLE, then a late memRValid is ignored and no rspValid occurs.
